// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int unsigned SA_N_DEFAULT = 4;

  // 2'd3 is unused and recovers to ST_IDLE in the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_cell.sv
// Single-bit full adder; the only adder logic in the serial add datapath.
// Port order is outputs first, then inputs.
module full_adder_cell (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches two N-bit operands on start, steps one
// shared full-adder cell per clock LSB first, then presents {cout,sum} with a
// one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned N = SA_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned     CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  sa_state_e        state_q, state_d;
  logic [N-1:0]     a_sh_q, a_sh_d;
  logic [N-1:0]     b_sh_q, b_sh_d;
  logic [N-1:0]     sum_sh_q, sum_sh_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cell_s, cell_co;
  logic [N-1:0]     sum_shifted;

  full_adder_cell u_cell (
    .s  (cell_s),
    .co (cell_co),
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q)
  );

  // Shift-and-insert written with >> and << so it stays legal for N=1.
  assign sum_shifted = (sum_sh_q >> 1) | (N'(cell_s) << (N - 1));

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shifted;
        carry_d  = cell_co;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          sum_d   = sum_shifted;
          cout_d  = cell_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);

endmodule
